// File: rtl/data_mem_if.sv
// Load/store port bundle for data_mem: enables, byte address, write data and registered read data.
interface data_mem_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 32
);
   logic              ren;
   logic              wen;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_i;
   logic [DATA_W-1:0] data_o;

   modport master (output ren, wen, addr, data_i, input data_o);
   modport slave  (input ren, wen, addr, data_i, output data_o);
endinterface

// File: rtl/data_mem.sv
// Single-port word data memory with a registered read port.
// DATA_MEM_FWD_EN selects write-first on a same-edge read+write; otherwise the read returns the old word.
module data_mem #(
   parameter int ADDR_W    = 20,
   parameter int DATA_W    = 32,
   parameter int MEM_WORDS = 1024
) (
   input logic       clk,
   input logic       rst_n,
   data_mem_if.slave bus
);
   localparam int IDX_W = $clog2(MEM_WORDS);

   logic [DATA_W-1:0] mem [MEM_WORDS] = '{default: '0};
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] data_o_d, data_o_q;

   // Dropping the byte offset and truncating gives the modulo-MEM_WORDS wrap.
   assign idx = IDX_W'(bus.addr >> 2);

   always_comb begin
      data_o_d = data_o_q;
      if (bus.ren) begin
`ifdef DATA_MEM_FWD_EN
         data_o_d = bus.wen ? bus.data_i : mem[idx];
`else
         data_o_d = mem[idx];
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_o_q <= '0;
      else        data_o_q <= data_o_d;
   end

   // Array is kept out of the reset domain so contents survive rst_n.
   always_ff @(posedge clk) begin
      if (rst_n && bus.wen) mem[idx] <= bus.data_i;
   end

   assign bus.data_o = data_o_q;
endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed plan steps then randomized traffic against an array model.
module tb_data_mem;
   localparam int ADDR_W    = 20;
   localparam int DATA_W    = 32;
   localparam int MEM_WORDS = 1024;
`ifdef DATA_MEM_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic [DATA_W-1:0] ref_mem [MEM_WORDS];
   logic [DATA_W-1:0] ref_q;

   data_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   data_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // One clock edge of traffic; model applies the memory rules, then data_o is checked 1ns later.
   task automatic op(input bit r, input bit w, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, input string tag);
      int i;
      bus.ren = r; bus.wen = w; bus.addr = a; bus.data_i = d;
      @(posedge clk);
      if (rst_n) begin
         i = int'(a / 4) % MEM_WORDS;
         if (r) ref_q = (FWD && w) ? d : ref_mem[i];
         if (w) ref_mem[i] = d;
      end
      #1 chk(tag, bus.data_o, ref_q);
   endtask

   initial begin
      logic [ADDR_W-1:0] a;
      for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = '0;
      ref_q = '0;
      rst_n = 1'b0;
      bus.ren = 1'b0; bus.wen = 1'b0; bus.addr = '0; bus.data_i = '0;
      #1 chk("reset_init", bus.data_o, 32'h0);
      op(1, 0, 20'h0, 32'h0, "in_reset_1");
      op(1, 0, 20'h0, 32'h0, "in_reset_2");
      rst_n = 1'b1;

      op(1, 0, 20'h0, 32'h0, "read0_after_reset");
      op(0, 1, 20'h4, 32'h3, "wr4");
      op(1, 0, 20'h4, 32'h0, "rd4");
      chk("rd4_k", bus.data_o, 32'h3);
      op(0, 1, 20'h8, 32'hF, "wr8");
      op(1, 0, 20'h8, 32'h0, "rd8");
      chk("rd8_k", bus.data_o, 32'hF);
      op(1, 0, 20'h4, 32'h0, "rerd4");
      chk("rerd4_k", bus.data_o, 32'h3);

      op(0, 1, 20'h10, 32'hDEADBEEF, "wr10");
      op(1, 0, 20'h13, 32'h0, "rd13_misaligned");
      chk("rd13_k", bus.data_o, 32'hDEADBEEF);
      op(1, 0, 20'h10 + MEM_WORDS * 4, 32'h0, "rd_wrap");
      chk("rd_wrap_k", bus.data_o, 32'hDEADBEEF);

      op(1, 0, 20'h8, 32'h0, "rd8_again");
      op(0, 0, 20'h4, 32'h0, "hold1");
      op(0, 0, 20'h10, 32'h0, "hold2");
      op(0, 0, 20'h13, 32'h0, "hold3");
      chk("hold_k", bus.data_o, 32'hF);

      op(1, 1, 20'h8, 32'h55, "simul");
      chk("simul_k", bus.data_o, FWD ? 32'h55 : 32'hF);
      op(1, 0, 20'h8, 32'h0, "after_simul");
      chk("after_simul_k", bus.data_o, 32'h55);

      // Reset between edges must clear data_o at once; edges under reset must not write.
      #2 rst_n = 1'b0;
      ref_q = '0;
      #1 chk("async_rst", bus.data_o, 32'h0);
      op(1, 1, 20'h8, 32'hBAD0BAD0, "wr_in_reset");
      #2 rst_n = 1'b1;
      op(1, 0, 20'h8, 32'h0, "retained8");
      chk("retained8_k", bus.data_o, 32'h55);

      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 1) == 0)
            a = ADDR_W'($urandom);
         else
            a = ADDR_W'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3) |
                        ($urandom_range(0, 3) << 12));
         op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
